// File: rtl/alu_share_arbiter.sv
// Two-port round-robin arbiter sharing one combinational ALU, with per-port
// one-entry response buffers. Define ALU_ARB_FIXED_PRIO_EN for fixed priority.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        req_valid_i,
    output logic [1:0]        req_ready_o,
    input  logic [DATA_W-1:0] req_a_i      [2],
    input  logic [DATA_W-1:0] req_b_i      [2],
    input  logic [OP_W-1:0]   req_op_i     [2],
    output logic [1:0]        rsp_valid_o,
    input  logic [1:0]        rsp_ready_i,
    output logic [DATA_W-1:0] rsp_result_o [2],
    output logic [1:0]        rsp_flag_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [OP_W-1:0]   alu_op_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_flag_i
);

    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_result_q [2];
    logic [DATA_W-1:0] rsp_result_d [2];
    logic [1:0]        rsp_flag_q, rsp_flag_d;
    logic [1:0]        eligible;
    logic [1:0]        grant;

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Index of the most recently granted port; the other one wins a tie.
    logic last_grant_q, last_grant_d;
`endif

    always_comb begin
        eligible = req_valid_i & (~rsp_valid_q | rsp_ready_i);
        grant    = 2'b00;
        if (!rst_i) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            if (eligible[0]) begin
                grant = 2'b01;
            end else if (eligible[1]) begin
                grant = 2'b10;
            end
`else
            if (&eligible) begin
                grant = last_grant_q ? 2'b01 : 2'b10;
            end else begin
                grant = eligible;
            end
`endif
        end
    end

    always_comb begin
        alu_a_o  = '0;
        alu_b_o  = '0;
        alu_op_o = '0;
        if (grant[0]) begin
            alu_a_o  = req_a_i[0];
            alu_b_o  = req_b_i[0];
            alu_op_o = req_op_i[0];
        end else if (grant[1]) begin
            alu_a_o  = req_a_i[1];
            alu_b_o  = req_b_i[1];
            alu_op_o = req_op_i[1];
        end
    end

    // A capture wins over a drain so a port can sustain one op per cycle.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_flag_d  = rsp_flag_q;
        for (int p = 0; p < 2; p++) begin
            rsp_result_d[p] = rsp_result_q[p];
            if (grant[p]) begin
                rsp_valid_d[p]  = 1'b1;
                rsp_result_d[p] = alu_result_i;
                rsp_flag_d[p]   = alu_flag_i;
            end else if (rsp_valid_q[p] && rsp_ready_i[p]) begin
                rsp_valid_d[p] = 1'b0;
            end
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        last_grant_d = last_grant_q;
        if (|grant) begin
            last_grant_d = grant[1];
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q     <= 2'b00;
            rsp_flag_q      <= 2'b00;
            rsp_result_q[0] <= '0;
            rsp_result_q[1] <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q    <= 1'b1;
`endif
        end else begin
            rsp_valid_q     <= rsp_valid_d;
            rsp_flag_q      <= rsp_flag_d;
            rsp_result_q[0] <= rsp_result_d[0];
            rsp_result_q[1] <= rsp_result_d[1];
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q    <= last_grant_d;
`endif
        end
    end

    assign req_ready_o     = grant;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_flag_o      = rsp_flag_q;
    assign rsp_result_o[0] = rsp_result_q[0];
    assign rsp_result_o[1] = rsp_result_q[1];

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and randomized bench for alu_share_arbiter with a stand-in ALU
// and a transaction-level reference model of grants and response slots.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a [2];
    logic [31:0] req_b [2];
    logic [4:0]  req_op [2];
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result [2];
    logic [1:0]  rsp_flag;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_flag;

    int errors = 0;
    int checks = 0;

    // reference model state
    int          last_m;
    bit          vld_m [2];
    logic [31:0] res_m [2];
    logic        flg_m [2];

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_W(32), .OP_W(5)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_op_i     (req_op),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result),
        .rsp_flag_o   (rsp_flag),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_op_o     (alu_op),
        .alu_result_i (alu_result),
        .alu_flag_i   (alu_flag)
    );

    function automatic logic [32:0] alu_ref(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [4:0] op);
        case (op)
            5'b00000: return {1'b0, a + b};
            5'b01000: return {a == b, a - b};
            5'b11100: return {$signed(a) < $signed(b), 32'd0};
            default:  return {1'b0, a ^ b};
        endcase
    endfunction

    assign {alu_flag, alu_result} = alu_ref(alu_a, alu_b, alu_op);

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input logic [1:0] v,
                        input logic [1:0] rr,
                        input logic [31:0] a0, input logic [31:0] b0,
                        input logic [4:0] op0,
                        input logic [31:0] a1, input logic [31:0] b1,
                        input logic [4:0] op1);
        int win;
        bit el [2];
        logic [31:0] ea, eb;
        logic [4:0]  eo;
        logic [32:0] fr;
        rst = r;
        req_valid = v;
        rsp_ready = rr;
        req_a[0] = a0; req_b[0] = b0; req_op[0] = op0;
        req_a[1] = a1; req_b[1] = b1; req_op[1] = op1;
        #4;
        for (int p = 0; p < 2; p++)
            el[p] = !r && v[p] && (!vld_m[p] || rr[p]);
`ifdef ALU_ARB_FIXED_PRIO_EN
        win = el[0] ? 0 : (el[1] ? 1 : -1);
`else
        if (el[0] && el[1]) win = 1 - last_m;
        else win = el[0] ? 0 : (el[1] ? 1 : -1);
`endif
        ea = 0; eb = 0; eo = 0;
        if (win == 0) begin ea = a0; eb = b0; eo = op0; end
        if (win == 1) begin ea = a1; eb = b1; eo = op1; end
        chk("req_ready", req_ready,
            (win == 0) ? 2'b01 : (win == 1) ? 2'b10 : 2'b00);
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("alu_op", alu_op, eo);
        @(posedge clk);
        #1;
        if (r) begin
            last_m = 1;
            for (int p = 0; p < 2; p++) begin
                vld_m[p] = 0; res_m[p] = 0; flg_m[p] = 0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (win == p) begin
                    fr = alu_ref(ea, eb, eo);
                    vld_m[p] = 1; res_m[p] = fr[31:0]; flg_m[p] = fr[32];
                end else if (vld_m[p] && rr[p]) begin
                    vld_m[p] = 0;
                end
            end
            if (win >= 0) last_m = win;
        end
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("rsp_valid%0d", p), rsp_valid[p], vld_m[p]);
            chk($sformatf("rsp_result%0d", p), rsp_result[p], res_m[p]);
            chk($sformatf("rsp_flag%0d", p), rsp_flag[p], flg_m[p]);
        end
    endtask

    task automatic idle(input logic [1:0] rr);
        step(0, 2'b00, rr, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        last_m = 1;
        for (int p = 0; p < 2; p++) begin
            vld_m[p] = 0; res_m[p] = 0; flg_m[p] = 0;
        end
        step(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        step(1, 2'b11, 2'b11, 1, 2, 0, 3, 4, 0);

        // single ADD on port 0
        step(0, 2'b01, 2'b01, 7, 5, 5'b00000, 0, 0, 0);
        chk("single_result", rsp_result[0], 32'd12);
        idle(2'b01);
        chk("single_drain", rsp_valid[0], 1'b0);

        // tie from reset: SUB on port 0, LTS on port 1
        step(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        step(0, 2'b11, 2'b11, 10, 3, 5'b01000, 32'hffff_ffff, 1, 5'b11100);
        chk("tie_first", rsp_result[0], 32'd7);
        step(0, 2'b11, 2'b11, 10, 3, 5'b01000, 32'hffff_ffff, 1, 5'b11100);
`ifndef ALU_ARB_FIXED_PRIO_EN
        chk("tie_second_flag", rsp_flag[1], 1'b1);
`endif
        for (int i = 0; i < 4; i++)
            step(0, 2'b11, 2'b11, i, 2, 5'b00000, i, 9, 5'b01000);

        // back-pressure on port 1
        idle(2'b11);
        step(0, 2'b10, 2'b00, 0, 0, 0, 40, 2, 5'b00000);
        for (int i = 0; i < 3; i++)
            step(0, 2'b11, 2'b01, 100 + i, 1, 5'b00000, 50, 2, 5'b01000);
        step(0, 2'b10, 2'b10, 0, 0, 0, 50, 2, 5'b01000);
        chk("bp_replace", rsp_result[1], 32'd48);

        // idle then tie to confirm arbitration state held
        idle(2'b11);
        idle(2'b11);
        step(0, 2'b11, 2'b11, 1, 1, 5'b00000, 2, 2, 5'b00000);

        // reset with both slots full
        step(0, 2'b01, 2'b00, 8, 8, 5'b00000, 0, 0, 0);
        step(0, 2'b10, 2'b00, 0, 0, 0, 9, 9, 5'b00000);
        step(1, 2'b11, 2'b00, 3, 3, 5'b00000, 4, 4, 5'b00000);
        chk("rst_valid", rsp_valid, 2'b00);
        step(0, 2'b11, 2'b11, 3, 3, 5'b00000, 4, 4, 5'b00000);
        chk("rst_tie", rsp_result[0], 32'd6);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [4:0] o0, o1;
            case ($urandom_range(0, 3))
                0: o0 = 5'b00000;
                1: o0 = 5'b01000;
                2: o0 = 5'b11100;
                default: o0 = 5'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0: o1 = 5'b00000;
                1: o1 = 5'b01000;
                2: o1 = 5'b11100;
                default: o1 = 5'($urandom);
            endcase
            step($urandom_range(0, 39) == 0, 2'($urandom), 2'($urandom),
                 $urandom, $urandom, o0, $urandom, $urandom, o1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
